// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational RV32I ALU between two requesters.
// Optional macro ALU_ARB_STATS_EN adds saturating per-port grant counters.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [1:0]        rq_valid_i,
    output logic [1:0]        rq_ready_o,
    input  logic [2:0]        rq_funct0_i,
    input  logic [2:0]        rq_funct1_i,
    input  logic [3:0]        rq_cntl0_i,
    input  logic [3:0]        rq_cntl1_i,
    input  logic [DATA_W-1:0] rq_op1_0_i,
    input  logic [DATA_W-1:0] rq_op1_1_i,
    input  logic [DATA_W-1:0] rq_op2_0_i,
    input  logic [DATA_W-1:0] rq_op2_1_i,
    output logic [1:0]        rs_valid_o,
    input  logic [1:0]        rs_ready_i,
    output logic [DATA_W-1:0] rs_result_o,
    output logic              rs_branch_o,
    output logic              rs_err_o,
    output logic [2:0]        alu_funct_o,
    output logic [3:0]        alu_cntl_o,
    output logic [DATA_W-1:0] alu_op1_o,
    output logic [DATA_W-1:0] alu_op2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_branch_i
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0_o,
    output logic [CNT_W-1:0]  gnt_cnt1_o
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic [1:0]        rs_valid_q;
    logic [DATA_W-1:0] rs_result_q;
    logic              rs_branch_q;
    logic              rs_err_q;
    logic [2:0]        alu_funct_q;
    logic [3:0]        alu_cntl_q;
    logic [DATA_W-1:0] alu_op1_q;
    logic [DATA_W-1:0] alu_op2_q;

    logic [1:0]        gnt;
    logic              hs;
    logic              sel_d;
    logic [2:0]        funct_d;
    logic [3:0]        cntl_d;
    logic [DATA_W-1:0] op1_d;
    logic [DATA_W-1:0] op2_d;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        gnt[0] = rq_valid_i[0] & (~rq_valid_i[1] | last_grant_q);
        gnt[1] = rq_valid_i[1] & (~rq_valid_i[0] | ~last_grant_q);
    end

    assign rq_ready_o = (state_q == IDLE && reset_n_i) ? gnt : 2'b00;
    assign hs         = |(rq_valid_i & rq_ready_o);
    assign sel_d      = gnt[1];
    assign funct_d    = sel_d ? rq_funct1_i : rq_funct0_i;
    assign cntl_d     = sel_d ? rq_cntl1_i  : rq_cntl0_i;
    assign op1_d      = sel_d ? rq_op1_1_i  : rq_op1_0_i;
    assign op2_d      = sel_d ? rq_op2_1_i  : rq_op2_0_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rs_valid_q   <= 2'b00;
            rs_result_q  <= '0;
            rs_branch_q  <= 1'b0;
            rs_err_q     <= 1'b0;
            alu_funct_q  <= '0;
            alu_cntl_q   <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        alu_funct_q  <= funct_d;
                        alu_cntl_q   <= cntl_d;
                        alu_op1_q    <= op1_d;
                        alu_op2_q    <= op2_d;
                        owner_q      <= sel_d;
                        last_grant_q <= sel_d;
                        // Illegal codes skip the ALU and answer straight away.
                        if (cntl_d > 4'd7) begin
                            rs_err_q    <= 1'b1;
                            rs_result_q <= '0;
                            rs_branch_q <= 1'b0;
                            rs_valid_q  <= sel_d ? 2'b10 : 2'b01;
                            state_q     <= RESP;
                        end else begin
                            state_q     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rs_result_q <= alu_result_i;
                    rs_branch_q <= alu_branch_i;
                    rs_err_q    <= 1'b0;
                    rs_valid_q  <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rs_ready_i[owner_q]) begin
                        rs_valid_q <= 2'b00;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rs_valid_o  = rs_valid_q;
    assign rs_result_o = rs_result_q;
    assign rs_branch_o = rs_branch_q;
    assign rs_err_o    = rs_err_q;
    assign alu_funct_o = alu_funct_q;
    assign alu_cntl_o  = alu_cntl_q;
    assign alu_op1_o   = alu_op1_q;
    assign alu_op2_o   = alu_op2_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0_q;
    logic [CNT_W-1:0] gnt_cnt1_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else if (hs) begin
            if (!sel_d && gnt_cnt0_q != '1) gnt_cnt0_q <= gnt_cnt0_q + 1'b1;
            if (sel_d && gnt_cnt1_q != '1)  gnt_cnt1_q <= gnt_cnt1_q + 1'b1;
        end
    end

    assign gnt_cnt0_o = gnt_cnt0_q;
    assign gnt_cnt1_o = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter with a transaction-level model.
module tb_alu_share_arbiter;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rq_valid, rq_ready, rs_valid, rs_ready;
    logic [2:0]  rq_funct0, rq_funct1, alu_funct;
    logic [3:0]  rq_cntl0, rq_cntl1, alu_cntl;
    logic [31:0] rq_op1_0, rq_op1_1, rq_op2_0, rq_op2_1;
    logic [31:0] rs_result, alu_op1, alu_op2, alu_result;
    logic        rs_branch, rs_err, alu_branch;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int last_g = 1;
    int mcnt0  = 0;
    int mcnt1  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .rq_valid_i(rq_valid), .rq_ready_o(rq_ready),
        .rq_funct0_i(rq_funct0), .rq_funct1_i(rq_funct1),
        .rq_cntl0_i(rq_cntl0), .rq_cntl1_i(rq_cntl1),
        .rq_op1_0_i(rq_op1_0), .rq_op1_1_i(rq_op1_1),
        .rq_op2_0_i(rq_op2_0), .rq_op2_1_i(rq_op2_1),
        .rs_valid_o(rs_valid), .rs_ready_i(rs_ready),
        .rs_result_o(rs_result), .rs_branch_o(rs_branch), .rs_err_o(rs_err),
        .alu_funct_o(alu_funct), .alu_cntl_o(alu_cntl),
        .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
        .alu_result_i(alu_result), .alu_branch_i(alu_branch)
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt0_o(gnt_cnt0), .gnt_cnt1_o(gnt_cnt1)
`endif
    );

    // Behavioural ALU: returns {branch, result}.
    function automatic logic [32:0] alu_fn(input logic [2:0] f, input logic [3:0] c,
                                           input logic [31:0] a, input logic [31:0] b);
        logic cond;
        case (c)
            4'd0: return {1'b0, a & b};
            4'd1: return {1'b0, a | b};
            4'd2: return {1'b0, a ^ b};
            4'd3: return {1'b0, a << b[4:0]};
            4'd4: return {1'b0, a >> b[4:0]};
            4'd5: return {1'b0, a - b};
            4'd6: return {1'b0, a + b};
            4'd7: begin
                case (f)
                    3'b000:  cond = (a == b);
                    3'b001:  cond = (a != b);
                    3'b100:  cond = ($signed(a) < $signed(b));
                    3'b101:  cond = ($signed(a) >= $signed(b));
                    3'b110:  cond = (a < b);
                    3'b111:  cond = (a >= b);
                    default: cond = 1'b0;
                endcase
                return {cond, cond ? 32'hFFFF_FFFF : 32'h0};
            end
            default: return 33'h0;
        endcase
    endfunction

    logic [32:0] alu_out;
    assign alu_out    = alu_fn(alu_funct, alu_cntl, alu_op1, alu_op2);
    assign alu_result = alu_out[31:0];
    assign alu_branch = alu_out[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: present the requests, expect the round-robin winner,
    // follow it through EXEC/RESP, stall the response for `hold` cycles, then accept.
    task automatic run_op(input logic [1:0] v,
                          input logic [2:0] f0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [2:0] f1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                          input int hold);
        int g;
        logic [1:0]  oh;
        logic [2:0]  ef;
        logic [3:0]  ec;
        logic [31:0] ea, eb;
        logic [32:0] er;
        g  = (v == 2'b11) ? ((last_g == 1) ? 0 : 1) : (v[1] ? 1 : 0);
        oh = (g == 1) ? 2'b10 : 2'b01;
        ef = g ? f1 : f0;  ec = g ? c1 : c0;
        ea = g ? a1 : a0;  eb = g ? b1 : b0;
        er = (ec > 4'd7) ? 33'h0 : alu_fn(ef, ec, ea, eb);
        last_g = g;
        if (g == 0) mcnt0 = (mcnt0 == CMAX) ? CMAX : mcnt0 + 1;
        else        mcnt1 = (mcnt1 == CMAX) ? CMAX : mcnt1 + 1;

        rq_valid = v;
        rq_funct0 = f0; rq_cntl0 = c0; rq_op1_0 = a0; rq_op2_0 = b0;
        rq_funct1 = f1; rq_cntl1 = c1; rq_op1_1 = a1; rq_op2_1 = b1;
        #1;
        chk("grant", {30'b0, rq_ready}, {30'b0, oh});
        tick();
        chk("busy_ready", {30'b0, rq_ready}, 32'h0);
        chk("alu_funct", {29'b0, alu_funct}, {29'b0, ef});
        chk("alu_cntl", {28'b0, alu_cntl}, {28'b0, ec});
        chk("alu_op1", alu_op1, ea);
        chk("alu_op2", alu_op2, eb);
        rq_valid = 2'b00;
        if (ec <= 4'd7) begin
            chk("exec_novalid", {30'b0, rs_valid}, 32'h0);
            tick();
        end
        chk("rs_valid", {30'b0, rs_valid}, {30'b0, oh});
        chk("rs_result", rs_result, er[31:0]);
        chk("rs_branch", {31'b0, rs_branch}, {31'b0, er[32]});
        chk("rs_err", {31'b0, rs_err}, {31'b0, ec > 4'd7});
        for (int i = 0; i < hold; i++) begin
            rs_ready = ~oh;
            tick();
            chk("hold_valid", {30'b0, rs_valid}, {30'b0, oh});
            chk("hold_result", rs_result, er[31:0]);
        end
        rs_ready = oh;
        tick();
        rs_ready = 2'b00;
        chk("accept_drop", {30'b0, rs_valid}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        rs_ready = 2'b00;
        rq_valid = 2'b11;
        rq_funct0 = '0; rq_cntl0 = '0; rq_op1_0 = '0; rq_op2_0 = '0;
        rq_funct1 = '0; rq_cntl1 = '0; rq_op1_1 = '0; rq_op2_1 = '0;
        tick(); tick();
        chk("rst_ready", {30'b0, rq_ready}, 32'h0);
        chk("rst_valid", {30'b0, rs_valid}, 32'h0);
        chk("rst_result", rs_result, 32'h0);
        chk("rst_err", {31'b0, rs_err}, 32'h0);
        chk("rst_op1", alu_op1, 32'h0);
        rq_valid = 2'b00;
        reset_n = 1'b1;
        tick();

        // T1 / T2
        run_op(2'b01, 3'b000, 4'b0110, 32'd5, 32'd7, 3'b000, 4'b0000, 32'd0, 32'd0, 0);
        run_op(2'b10, 3'b000, 4'b0000, 32'd0, 32'd0, 3'b110, 4'b0111, 32'd1, 32'd2, 1);
        // T3: both requesting, alternation with 5-cycle stalls
        for (int k = 0; k < 4; k++)
            run_op(2'b11, 3'd0, 4'd6, 32'd10 + k, 32'd3, 3'd0, 4'd5, 32'd100, 32'd1 + k, 5);
`ifdef ALU_ARB_STATS_EN
        chk("gnt_cnt0", {29'b0, gnt_cnt0}, mcnt0);
        chk("gnt_cnt1", {29'b0, gnt_cnt1}, mcnt1);
`endif
        // T4: illegal control code
        run_op(2'b01, 3'b010, 4'b1001, 32'hDEAD_BEEF, 32'h1234_5678, 3'd0, 4'd0, 32'd0, 32'd0, 2);

        tick();
        chk("idle_noreq", {30'b0, rq_ready}, 32'h0);

        // T5: reset while an op is in EXEC
        rq_valid = 2'b01; rq_cntl0 = 4'd6; rq_op1_0 = 32'd9; rq_op2_0 = 32'd9;
        tick();
        rq_valid = 2'b00;
        reset_n = 1'b0;
        tick();
        chk("t5_valid", {30'b0, rs_valid}, 32'h0);
        chk("t5_result", rs_result, 32'h0);
        chk("t5_branch", {31'b0, rs_branch}, 32'h0);
        chk("t5_op1", alu_op1, 32'h0);
        chk("t5_cntl", {28'b0, alu_cntl}, 32'h0);
        tick();
        chk("t5_novalid", {30'b0, rs_valid}, 32'h0);
        reset_n = 1'b1;
        last_g = 1; mcnt0 = 0; mcnt1 = 0;
        run_op(2'b11, 3'd0, 4'd6, 32'd1, 32'd1, 3'd0, 4'd6, 32'd2, 32'd2, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic [1:0] v;
            logic [3:0] c0, c1;
            v  = 2'($urandom_range(1, 3));
            c0 = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            c1 = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            run_op(v, 3'($urandom), c0, $urandom, $urandom,
                      3'($urandom), c1, $urandom, $urandom, $urandom_range(0, 3));
        end
`ifdef ALU_ARB_STATS_EN
        chk("sat_cnt0", {29'b0, gnt_cnt0}, mcnt0);
        chk("sat_cnt1", {29'b0, gnt_cnt1}, mcnt1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
